// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode constants, state types and instruction classifiers for the
// LC3 pipeline controller.
package lc3_ctrl_pkg;

  localparam int OPC_W = 4;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_BR  = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_LD  = 4'b0010;
  localparam opcode_t OP_ST  = 4'b0011;
  localparam opcode_t OP_AND = 4'b0101;
  localparam opcode_t OP_LDR = 4'b0110;
  localparam opcode_t OP_STR = 4'b0111;
  localparam opcode_t OP_NOT = 4'b1001;
  localparam opcode_t OP_LDI = 4'b1010;
  localparam opcode_t OP_STI = 4'b1011;
  localparam opcode_t OP_JMP = 4'b1100;
  localparam opcode_t OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    IND   = 2'd1,
    WRITE = 2'd2,
    IDLE  = 2'd3
  } mem_state_t;

  typedef enum logic [1:0] {
    RUN,
    MEM,
    BR_WAIT
  } fsm_t;

  function automatic opcode_t opcode(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic is_load(input logic [15:0] instr);
    return opcode(instr) inside {OP_LD, OP_LDR, OP_LDI};
  endfunction

  function automatic logic is_store(input logic [15:0] instr);
    return opcode(instr) inside {OP_ST, OP_STR, OP_STI};
  endfunction

  function automatic logic is_indirect(input logic [15:0] instr);
    return opcode(instr) inside {OP_LDI, OP_STI};
  endfunction

  function automatic logic writes_reg(input logic [15:0] instr);
    return opcode(instr) inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
  endfunction

  function automatic logic is_branch(input logic [15:0] instr);
    return opcode(instr) inside {OP_BR, OP_JMP};
  endfunction

  // Register fields: destination, first source, second source.
  function automatic logic [2:0] dst_reg(input logic [15:0] instr);
    return instr[11:9];
  endfunction

  function automatic logic [2:0] src1_reg(input logic [15:0] instr);
    return instr[8:6];
  endfunction

  // Second source exists only for the register form of ADD/AND.
  function automatic logic src2_used(input logic [15:0] instr);
    return (opcode(instr) inside {OP_ADD, OP_AND}) && !instr[5];
  endfunction

  function automatic logic [2:0] src2_reg(input logic [15:0] instr);
    return instr[2:0];
  endfunction

endpackage

// File: rtl/lc3_pipeline_ctrl_if.sv
// Bus between the LC3 datapath/memory handshakes and the pipeline controller.
interface lc3_pipeline_ctrl_if;
  import lc3_ctrl_pkg::*;

  logic        complete_data;
  logic        complete_instr;
  logic [15:0] IR;
  logic [2:0]  psr;
  logic [15:0] IR_Exec;
  logic [15:0] IMem_dout;
  logic [2:0]  NZP;

  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  mem_state_t  mem_state;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;

  modport master (
    output complete_data, complete_instr, IR, psr, IR_Exec, IMem_dout, NZP,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, mem_state, br_taken,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
  );

  modport slave (
    input  complete_data, complete_instr, IR, psr, IR_Exec, IMem_dout, NZP,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, mem_state, br_taken,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
  );

endinterface

// File: rtl/lc3_bypass_unit.sv
// Combinational hazard compare between the execute-stage producer and the
// decode-stage consumer; selects ALU or memory forwarding per source operand.
module lc3_bypass_unit
  import lc3_ctrl_pkg::*;
(
  input  logic        exe_valid,
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  logic alu_src;
  logic mem_src;
  logic hit_1;
  logic hit_2;

  // Match the producer's destination against each consumer source field.
  always_comb begin
    alu_src      = exe_valid && writes_reg(ir_exec);
    mem_src      = exe_valid && is_load(ir_exec);
    hit_1        = dst_reg(ir_exec) == src1_reg(ir);
    hit_2        = src2_used(ir) && (dst_reg(ir_exec) == src2_reg(ir));
    bypass_alu_1 = alu_src && hit_1;
    bypass_alu_2 = alu_src && hit_2;
    bypass_mem_1 = mem_src && hit_1;
    bypass_mem_2 = mem_src && hit_2;
  end

endmodule

// File: rtl/lc3_pipeline_ctrl.sv
// LC3 pipeline sequencing controller: stage enables, memory-access sequencing
// and branch freeze/resolution.
module lc3_pipeline_ctrl
  import lc3_ctrl_pkg::*;
#(
  parameter int BR_DRAIN = 3
) (
  input  logic               clock,
  input  logic               reset,
  lc3_pipeline_ctrl_if.slave bus
);

  localparam int DW = (BR_DRAIN > 1) ? $clog2(BR_DRAIN) : 1;

  fsm_t          state, state_nx;
  mem_state_t    mem_st, mem_st_nx;
  logic          upc, upc_nx;
  logic          fetch, fetch_nx;
  logic          dec, dec_nx;
  logic          exe, exe_nx;
  logic          wb, wb_nx;
  logic          br, br_nx;
  logic          mem_load, mem_load_nx;
  logic          dec_save, dec_save_nx;   // decode enable to restore after MEM
  logic          exe_save, exe_save_nx;   // execute enable to restore after MEM
  logic [DW-1:0] drain_cnt, drain_cnt_nx;
  logic          br_in_exe;
  logic          br_cond;

  assign br_in_exe = exe && is_branch(bus.IR_Exec);
  assign br_cond   = (opcode(bus.IR_Exec) == OP_JMP) || (|(bus.NZP & bus.psr));

  // Next-state and next-enable decision for the three-state sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_nx     = state;
    mem_st_nx    = mem_st;
    upc_nx       = upc;
    fetch_nx     = fetch;
    dec_nx       = dec;
    exe_nx       = exe;
    wb_nx        = wb;
    br_nx        = 1'b0;
    mem_load_nx  = mem_load;
    dec_save_nx  = dec_save;
    exe_save_nx  = exe_save;
    drain_cnt_nx = drain_cnt;
    unique case (state)
      RUN: begin
        if (bus.complete_instr) begin
          if (exe && (is_load(bus.IR_Exec) || is_store(bus.IR_Exec))) begin
            // Memory op wins over a branch seen at fetch; IMem_dout is re-examined on exit.
            state_nx    = MEM;
            mem_load_nx = is_load(bus.IR_Exec);
            dec_save_nx = fetch;
            exe_save_nx = dec;
            if (is_indirect(bus.IR_Exec))  mem_st_nx = IND;
            else if (is_load(bus.IR_Exec)) mem_st_nx = READ;
            else                           mem_st_nx = WRITE;
            upc_nx   = 1'b0;
            fetch_nx = 1'b0;
            dec_nx   = 1'b0;
            exe_nx   = 1'b0;
            wb_nx    = 1'b0;
          end else begin
            dec_nx = fetch;
            exe_nx = dec;
            wb_nx  = exe && writes_reg(bus.IR_Exec);
            if (fetch && is_branch(bus.IMem_dout)) begin
              state_nx     = BR_WAIT;
              drain_cnt_nx = '0;
              upc_nx       = 1'b0;
              fetch_nx     = 1'b0;
            end else begin
              upc_nx   = 1'b1;
              fetch_nx = 1'b1;
            end
          end
        end
      end
      MEM: begin
        if (bus.complete_data) begin
          if (mem_st == IND) begin
            mem_st_nx = mem_load ? READ : WRITE;
          end else begin
            state_nx  = RUN;
            mem_st_nx = IDLE;
            upc_nx    = 1'b1;
            fetch_nx  = 1'b1;
            dec_nx    = dec_save;
            exe_nx    = exe_save;
            wb_nx     = mem_load;
          end
        end
      end
      BR_WAIT: begin
        dec_nx = fetch;
        exe_nx = dec;
        wb_nx  = exe && writes_reg(bus.IR_Exec);
        if (br_in_exe || (drain_cnt == DW'(BR_DRAIN - 1))) begin
          br_nx    = br_in_exe && br_cond;
          upc_nx   = 1'b1;
          fetch_nx = 1'b1;
          state_nx = RUN;
        end else begin
          drain_cnt_nx = drain_cnt + DW'(1);
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // State and enable registers; synchronous reset overrides any access in flight.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= RUN;
      mem_st    <= IDLE;
      upc       <= 1'b1;
      fetch     <= 1'b1;
      dec       <= 1'b0;
      exe       <= 1'b0;
      wb        <= 1'b0;
      br        <= 1'b0;
      mem_load  <= 1'b0;
      dec_save  <= 1'b0;
      exe_save  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      mem_st    <= mem_st_nx;
      upc       <= upc_nx;
      fetch     <= fetch_nx;
      dec       <= dec_nx;
      exe       <= exe_nx;
      wb        <= wb_nx;
      br        <= br_nx;
      mem_load  <= mem_load_nx;
      dec_save  <= dec_save_nx;
      exe_save  <= exe_save_nx;
      drain_cnt <= drain_cnt_nx;
    end
  end

  assign bus.enable_updatePC  = upc;
  assign bus.enable_fetch     = fetch;
  assign bus.enable_decode    = dec;
  assign bus.enable_execute   = exe;
  assign bus.enable_writeback = wb;
  assign bus.mem_state        = mem_st;
  assign bus.br_taken         = br;

  lc3_bypass_unit u_bypass (
    .exe_valid    (exe),
    .ir           (bus.IR),
    .ir_exec      (bus.IR_Exec),
    .bypass_alu_1 (bus.bypass_alu_1),
    .bypass_alu_2 (bus.bypass_alu_2),
    .bypass_mem_1 (bus.bypass_mem_1),
    .bypass_mem_2 (bus.bypass_mem_2)
  );

endmodule
